// File: rtl/ram_pattern_loader.sv
// Port-B writer for the pattern RAM: streams words to consecutive (wrapping) addresses,
// then optionally reads them back and compares an additive checksum.
module ram_pattern_loader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1,
  parameter int VERIFY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   length_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic [ADDR_W-1:0] ram_addr_b_o,
  output logic              ram_wr_b_o,
  output logic [DATA_W-1:0] ram_din_b_o,
  input  logic [DATA_W-1:0] ram_qb_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [DATA_W-1:0] checksum_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W:0]     rcv_q;
  logic [DATA_W-1:0]   wsum_q;
  logic [DATA_W-1:0]   rsum_q;
  logic [RD_LAT:0]     rd_pipe_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic                ram_wr_q;
  logic [DATA_W-1:0]   ram_din_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic [DATA_W-1:0]   checksum_q;

  logic                hs;
  logic                last_wr;
  logic                last_rd;
  logic                rd_issue;
  logic                rd_capture;
  logic [DATA_W-1:0]   wsum_d;
  logic [DATA_W-1:0]   rsum_d;
  logic [ADDR_W-1:0]   addr_d;

  assign s_ready_o  = (state_q == ST_LOAD);
  assign hs         = s_ready_o & s_valid_i;
  assign wsum_d     = wsum_q + s_data_i;
  assign rsum_d     = rsum_q + ram_qb_i;
  // Address add is ADDR_W wide so it wraps at the top of the RAM.
  assign addr_d     = base_q + cnt_q[ADDR_W-1:0];
  assign last_wr    = (cnt_q == len_q - 1'b1);
  assign last_rd    = (rcv_q == len_q - 1'b1);
  assign rd_issue   = (state_q == ST_VERIFY) && (cnt_q != len_q);
  // A read issued on this edge returns data RD_LAT cycles after its address appears.
  assign rd_capture = rd_pipe_q[RD_LAT];

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rcv_q      <= '0;
      wsum_q     <= '0;
      rsum_q     <= '0;
      rd_pipe_q  <= '0;
      ram_addr_q <= '0;
      ram_wr_q   <= 1'b0;
      ram_din_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      checksum_q <= '0;
    end else begin
      ram_wr_q  <= 1'b0;
      done_q    <= 1'b0;
      rd_pipe_q <= {rd_pipe_q[RD_LAT-1:0], rd_issue};

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            base_q     <= base_addr_i;
            len_q      <= length_i;
            cnt_q      <= '0;
            rcv_q      <= '0;
            wsum_q     <= '0;
            rsum_q     <= '0;
            checksum_q <= '0;
            error_q    <= 1'b0;
            busy_q     <= 1'b1;
            if (length_i == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (hs) begin
            ram_wr_q   <= 1'b1;
            ram_addr_q <= addr_d;
            ram_din_q  <= s_data_i;
            wsum_q     <= wsum_d;
            if (last_wr) begin
              if (VERIFY != 0) begin
                state_q <= ST_VERIFY;
                cnt_q   <= '0;
              end else begin
                state_q    <= ST_DONE;
                done_q     <= 1'b1;
                checksum_q <= wsum_d;
                error_q    <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        ST_VERIFY: begin
          // The first VERIFY cycle carries the final write on port B; reads follow it.
          if (rd_issue) begin
            ram_addr_q <= addr_d;
            cnt_q      <= cnt_q + 1'b1;
          end
          if (rd_capture) begin
            rsum_q <= rsum_d;
            rcv_q  <= rcv_q + 1'b1;
            if (last_rd) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              checksum_q <= wsum_q;
              error_q    <= (rsum_d != wsum_q);
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_addr_b_o = ram_addr_q;
  assign ram_wr_b_o   = ram_wr_q;
  assign ram_din_b_o  = ram_din_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign checksum_o   = checksum_q;

endmodule

// File: tb/tb_ram_pattern_loader.sv
// Bench for ram_pattern_loader: behavioural port-B RAM, write scoreboard and per-scenario tasks.
module tb_ram_pattern_loader;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [10:0] base_addr_i;
  logic [11:0] length_i;
  logic        s_valid_i;
  logic [15:0] s_data_i;
  logic        s_ready_o;
  logic [10:0] ram_addr_b_o;
  logic        ram_wr_b_o;
  logic [15:0] ram_din_b_o;
  logic [15:0] ram_qb_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] checksum_o;

  ram_pattern_loader #(
    .ADDR_W(11), .DATA_W(16), .RD_LAT(1), .VERIFY(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .length_i    (length_i),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_o),
    .ram_addr_b_o(ram_addr_b_o),
    .ram_wr_b_o  (ram_wr_b_o),
    .ram_din_b_o (ram_din_b_o),
    .ram_qb_i    (ram_qb_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .checksum_o  (checksum_o)
  );

  typedef struct {
    logic [10:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] mem [0:2047];
  logic [15:0] tx_data [0:15];
  logic        flip_en;
  int          checks;
  int          errors;
  int          cyc;
  int          start_cyc;
  int          wr_count;
  bit          done_seen;
  int          done_rel;
  logic [15:0] done_cs;
  logic        done_err;
  logic [15:0] exp_sum;
  logic        wr_log [0:63];
  logic [10:0] addr_log [0:63];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural port-B RAM with one cycle of read latency; can corrupt address 2 on read.
  always @(posedge clk) begin
    if (ram_wr_b_o) mem[ram_addr_b_o] <= ram_din_b_o;
    ram_qb_i <= mem[ram_addr_b_o] ^ {15'b0, (flip_en && ram_addr_b_o == 11'd2)};
  end

  always @(negedge clk) begin
    int rel;
    wr_t e;
    rel = cyc - start_cyc;
    if (rel >= 0 && rel < 64) begin
      wr_log[rel]   = ram_wr_b_o;
      addr_log[rel] = ram_addr_b_o;
    end
    if (ram_wr_b_o) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h cycle=%0d, no write expected", ram_addr_b_o, ram_din_b_o, rel);
      end else begin
        e = exp_q.pop_front();
        if (ram_addr_b_o !== e.addr || ram_din_b_o !== e.data || rel !== e.cyc) begin
          errors++;
          $display("FAIL write_match: got addr=%h data=%h cycle=%0d, expected addr=%h data=%h cycle=%0d",
                   ram_addr_b_o, ram_din_b_o, rel, e.addr, e.data, e.cyc);
        end
      end
    end
    if (done_o) begin
      done_seen = 1'b1;
      done_rel  = rel;
      done_cs   = checksum_o;
      done_err  = error_o;
    end
  end

  task automatic run_load(input logic [10:0] base, input int len, input bit gaps, input bit pulse_start);
    int  idx;
    int  budget;
    bit  phase;
    wr_t e;
    @(posedge clk); #1;
    start_cyc   = cyc;
    done_seen   = 1'b0;
    wr_count    = 0;
    exp_sum     = 16'h0000;
    start_i     = 1'b1;
    base_addr_i = base;
    length_i    = 12'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
    idx     = 0;
    budget  = 0;
    phase   = 1'b1;
    while (idx < len && budget < 100) begin
      s_valid_i = gaps ? phase : 1'b1;
      phase     = ~phase;
      s_data_i  = s_valid_i ? tx_data[idx] : 16'hDEAD;
      start_i   = pulse_start && idx == 1;
      @(negedge clk);
      if (s_valid_i && s_ready_o) begin
        e.addr  = base + 11'(idx);
        e.data  = tx_data[idx];
        e.cyc   = (cyc - start_cyc) + 1;
        exp_q.push_back(e);
        exp_sum = exp_sum + tx_data[idx];
        idx++;
      end
      @(posedge clk); #1;
      budget++;
    end
    start_i   = 1'b0;
    s_valid_i = 1'b1;
    checks++;
    if (idx != len) begin
      errors++;
      $display("FAIL accept_count: accepted %0d words, expected %0d", idx, len);
    end
    @(negedge clk); #1;
    checks++;
    if (s_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_last: s_ready=%b, expected 0", s_ready_o);
    end
    budget = 0;
    while (!done_seen && budget < 200) begin
      @(negedge clk); #1;
      budget++;
    end
    s_valid_i = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL done_timeout: no done within 200 cycles");
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: %0d expected writes never seen", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || error_o !== 1'b0 || checksum_o !== 16'h0 ||
        s_ready_o !== 1'b0 || ram_wr_b_o !== 1'b0 || ram_addr_b_o !== 11'h0 || ram_din_b_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b cs=%h rdy=%b wr=%b addr=%h din=%h, expected all 0",
               busy_o, done_o, error_o, checksum_o, s_ready_o, ram_wr_b_o, ram_addr_b_o, ram_din_b_o);
    end
  endtask

  task automatic test_basic();
    tx_data[0] = 16'hA5A5; tx_data[1] = 16'h0001; tx_data[2] = 16'h0002; tx_data[3] = 16'hFFFF;
    flip_en = 1'b0;
    run_load(11'h000, 4, 1'b0, 1'b1);
    checks++;
    if (done_rel != 11) begin
      errors++;
      $display("FAIL basic_done_cycle: done at %0d, expected 11", done_rel);
    end
    checks++;
    if (done_cs !== 16'hA5A7 || done_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: checksum=%h error=%b, expected A5A7 0", done_cs, done_err);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (wr_count != 4 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_ignored_start: writes=%0d busy=%b, expected 4 0", wr_count, busy_o);
    end
    checks++;
    if (checksum_o !== 16'hA5A7 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: checksum=%h error=%b, expected A5A7 0 held", checksum_o, error_o);
    end
  endtask

  task automatic test_wrap();
    logic [10:0] ea;
    for (int i = 0; i < 4; i++) tx_data[i] = 16'($urandom);
    flip_en = 1'b0;
    run_load(11'h7FE, 4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ea = 11'h7FE + 11'(i);
      checks++;
      if (addr_log[6+i] !== ea || wr_log[6+i] !== 1'b0) begin
        errors++;
        $display("FAIL wrap_read_addr%0d: addr=%h wr=%b, expected %h 0", i, addr_log[6+i], wr_log[6+i], ea);
      end
    end
    checks++;
    if (done_rel != 11 || done_cs !== exp_sum || done_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_result: cycle=%0d checksum=%h error=%b, expected 11 %h 0", done_rel, done_cs, done_err, exp_sum);
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 3; i++) tx_data[i] = 16'($urandom);
    flip_en = 1'b0;
    run_load(11'h123, 3, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_count != 3) begin
      errors++;
      $display("FAIL gaps_write_count: %0d writes, expected 3", wr_count);
    end
    checks++;
    if (done_cs !== exp_sum || done_err !== 1'b0) begin
      errors++;
      $display("FAIL gaps_result: checksum=%h error=%b, expected %h 0", done_cs, done_err, exp_sum);
    end
  endtask

  task automatic test_flip();
    tx_data[0] = 16'hA5A5; tx_data[1] = 16'h0001; tx_data[2] = 16'h0002; tx_data[3] = 16'hFFFF;
    flip_en = 1'b1;
    run_load(11'h000, 4, 1'b0, 1'b0);
    flip_en = 1'b0;
    checks++;
    if (done_rel != 11 || done_cs !== 16'hA5A7 || done_err !== 1'b1) begin
      errors++;
      $display("FAIL flip_result: cycle=%0d checksum=%h error=%b, expected 11 A5A7 1", done_rel, done_cs, done_err);
    end
  endtask

  task automatic test_zero_len();
    run_load(11'h055, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_rel != 1 || wr_count != 0) begin
      errors++;
      $display("FAIL zero_len_timing: done at %0d writes=%0d, expected 1 0", done_rel, wr_count);
    end
    checks++;
    if (done_cs !== 16'h0 || done_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_result: checksum=%h error=%b, expected 0 0", done_cs, done_err);
    end
  endtask

  task automatic test_reset_mid();
    wr_t e;
    @(posedge clk); #1;
    start_cyc   = cyc;
    done_seen   = 1'b0;
    start_i     = 1'b1;
    base_addr_i = 11'h200;
    length_i    = 12'd8;
    @(posedge clk); #1;
    start_i   = 1'b0;
    s_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_data_i = 16'h1000 + 16'(i);
      e.addr   = 11'h200 + 11'(i);
      e.data   = s_data_i;
      e.cyc    = 2 + i;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || s_ready_o !== 1'b0 || ram_wr_b_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy=%b ready=%b wr=%b, expected 0 0 0", busy_o, s_ready_o, ram_wr_b_o);
    end
    s_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (done_seen) begin
      errors++;
      $display("FAIL reset_mid_done: done pulse seen after reset, expected none");
    end
    tx_data[0] = 16'h1234;
    run_load(11'h100, 1, 1'b0, 1'b0);
    checks++;
    if (done_rel != 5 || done_cs !== 16'h1234 || done_err !== 1'b0 || wr_count != 1) begin
      errors++;
      $display("FAIL reset_mid_reload: cycle=%0d checksum=%h error=%b writes=%0d, expected 5 1234 0 1",
               done_rel, done_cs, done_err, wr_count);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start_i     = 1'b0;
    base_addr_i = '0;
    length_i    = '0;
    s_valid_i   = 1'b0;
    s_data_i    = '0;
    flip_en     = 1'b0;
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    start_cyc   = 0;
    wr_count    = 0;
    done_seen   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_basic();
    test_wrap();
    test_gaps();
    test_flip();
    test_zero_len();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
